// File: rtl/up_counter_ctrl_if.sv
// ---------------------------------------------------------------------------
// up_counter_ctrl_if
// Groups the signals between the counter controller and its environment:
// the two requesters and the external loadable up counter.
//
//   req        [1:0]        interval request, bit i from requester i (level)
//   req_data0  [DATA_W-1:0] start value for requester 0
//   req_data1  [DATA_W-1:0] start value for requester 1
//   count_in   [DATA_W-1:0] current count returned by the up counter
//   cnt_load                load strobe to the counter
//   cnt_data   [DATA_W-1:0] load value to the counter
//   gnt        [1:0]        one-hot owner of the counter, 2'b00 when free
//   done       [1:0]        one-cycle completion pulse to the owner
//   busy                    high whenever the controller is not idle
//
// Modports: master = requesters/counter side, slave = controller side.
// ---------------------------------------------------------------------------
interface up_counter_ctrl_if #(
    parameter int DATA_W = 4
);
    logic [1:0]        req;
    logic [DATA_W-1:0] req_data0;
    logic [DATA_W-1:0] req_data1;
    logic [DATA_W-1:0] count_in;
    logic              cnt_load;
    logic [DATA_W-1:0] cnt_data;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic              busy;

    modport master (
        output req, req_data0, req_data1, count_in,
        input  cnt_load, cnt_data, gnt, done, busy
    );

    modport slave (
        input  req, req_data0, req_data1, count_in,
        output cnt_load, cnt_data, gnt, done, busy
    );
endinterface

// File: rtl/up_counter_ctrl.sv
// ---------------------------------------------------------------------------
// up_counter_ctrl
// Shares one external loadable up counter between two requesters. A winner
// is chosen in IDLE, its start value is loaded into the counter (LOAD), the
// counter is watched until it reaches all-ones (RUN), and the winner gets a
// one-cycle done pulse (DONE) before the block returns to IDLE.
//
// Ports:
//   clk   input  single clock, rising edge
//   rst   input  asynchronous, active-low reset
//   bus   slave modport of up_counter_ctrl_if (req, req_data0/1, count_in,
//         cnt_load, cnt_data, gnt, done, busy)
//
// Configuration macro:
//   CNT_CTRL_FIXED_PRIO_EN  defined   -> fixed priority, req[0] always wins,
//                                        no round-robin pointer
//                           undefined -> round-robin between the requesters
// ---------------------------------------------------------------------------
module up_counter_ctrl #(
    parameter int DATA_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    up_counter_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    logic   pick;      // index of the requester that wins this arbitration

`ifdef CNT_CTRL_FIXED_PRIO_EN
    // Requester 0 wins whenever it is asking.
    always_comb begin
        pick = 1'b0;
        if (!bus.req[0]) pick = 1'b1;
    end
`else
    logic ptr;         // favoured requester when both are asking

    always_comb begin
        pick = 1'b0;
        if (bus.req == 2'b11) pick = ptr;
        else                  pick = bus.req[1];
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            bus.gnt      <= 2'b00;
            bus.done     <= 2'b00;
            bus.cnt_load <= 1'b0;
            bus.cnt_data <= '0;
            bus.busy     <= 1'b0;
`ifndef CNT_CTRL_FIXED_PRIO_EN
            ptr          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req != 2'b00) begin
                        // Start value is captured here so later changes on
                        // req_data* cannot disturb the running interval.
                        bus.gnt      <= pick ? 2'b10 : 2'b01;
                        bus.cnt_data <= pick ? bus.req_data1 : bus.req_data0;
                        bus.cnt_load <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    bus.cnt_load <= 1'b0;
                    state        <= RUN;
                end
                RUN: begin
                    if (bus.count_in == '1) begin
                        // gnt is one-hot, so it doubles as the done mask.
                        bus.done <= bus.gnt;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 2'b00;
                    bus.gnt  <= 2'b00;
                    bus.busy <= 1'b0;
`ifndef CNT_CTRL_FIXED_PRIO_EN
                    // Favour the requester that was not just served.
                    ptr      <= bus.gnt[0];
`endif
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_up_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_up_counter_ctrl
// Directed bench for up_counter_ctrl. A simple loadable up counter model
// closes the loop on count_in. Expected values are hand-computed: with start
// value D, done appears 2+(15-D) edges after the grant edge.
// ---------------------------------------------------------------------------
module tb_up_counter_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [3:0] cnt = 4'd0;

    int vec_cnt = 0;
    int err_cnt = 0;

    up_counter_ctrl_if #(.DATA_W(4)) bus ();

    up_counter_ctrl #(.DATA_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // External loadable up counter.
    always @(posedge clk) begin
        if (bus.cnt_load) cnt <= bus.cnt_data;
        else              cnt <= cnt + 4'd1;
    end
    assign bus.count_in = cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.req = 2'b00;
        bus.req_data0 = 4'd0;
        bus.req_data1 = 4'd0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Runs n edges after the grant edge, recording load/done activity.
    // At edge index chg_at, req_data0 becomes 9 and req drops.
    task automatic observe(input int n, input int chg_at,
                           output int loads, output int dones,
                           output int done_at, output logic [1:0] done_val);
        loads = 0; dones = 0; done_at = -1; done_val = 2'b00;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (i == chg_at) begin
                bus.req_data0 = 4'd9;
                bus.req = 2'b00;
            end
            if (bus.cnt_load) loads++;
            if (bus.done != 2'b00) begin
                dones++;
                if (done_at < 0) begin
                    done_at  = i;
                    done_val = bus.done;
                end
            end
        end
    endtask

    int loads, dones, done_at;
    logic [1:0] done_val;
    logic [1:0] grants [4];
    int ng, bad;
    logic [1:0] prev_gnt;

    initial begin
        bus.req = 2'b00;
        bus.req_data0 = 4'd0;
        bus.req_data1 = 4'd0;

        // Reset state
        #2;
        chk("rst_gnt",      bus.gnt,      2'b00);
        chk("rst_done",     bus.done,     2'b00);
        chk("rst_cnt_load", bus.cnt_load, 1'b0);
        chk("rst_cnt_data", bus.cnt_data, 4'd0);
        chk("rst_busy",     bus.busy,     1'b0);

        // Single request, D=10: done 7 edges after the grant edge
        do_reset();
        bus.req = 2'b01; bus.req_data0 = 4'd10;
        tick();
        chk("r26_gnt",      bus.gnt,      2'b01);
        chk("r26_load",     bus.cnt_load, 1'b1);
        chk("r26_cnt_data", bus.cnt_data, 4'd10);
        chk("r26_busy",     bus.busy,     1'b1);
        bus.req = 2'b00;
        observe(12, 0, loads, dones, done_at, done_val);
        chk("r26_loads",    loads,    0);
        chk("r26_dones",    dones,    1);
        chk("r26_done_at",  done_at,  7);
        chk("r26_done_val", done_val, 2'b01);
        chk("r26_busy_end", bus.busy, 1'b0);
        chk("r26_gnt_end",  bus.gnt,  2'b00);

        // D=15: RUN lasts one cycle, done 2 edges after the grant edge
        do_reset();
        bus.req = 2'b01; bus.req_data0 = 4'hF;
        tick();
        chk("r28_gnt", bus.gnt, 2'b01);
        bus.req = 2'b00;
        observe(6, 0, loads, dones, done_at, done_val);
        chk("r28_done_at",  done_at,  2);
        chk("r28_done_val", done_val, 2'b01);
        chk("r28_dones",    dones,    1);

        // Data change and req drop during RUN are ignored
        do_reset();
        bus.req = 2'b01; bus.req_data0 = 4'd2;
        tick();
        chk("r29_cnt_data", bus.cnt_data, 4'd2);
        observe(18, 3, loads, dones, done_at, done_val);
        chk("r29_done_at",  done_at,  15);
        chk("r29_done_val", done_val, 2'b01);
        chk("r29_dones",    dones,    1);
        chk("r29_cnt_data_end", bus.cnt_data, 4'd2);

        // Both requesting continuously: grant order
        do_reset();
        bus.req = 2'b11; bus.req_data0 = 4'd13; bus.req_data1 = 4'd14;
        ng = 0; bad = 0; prev_gnt = 2'b00;
        for (int i = 0; i < 60 && ng < 4; i++) begin
            tick();
            if (bus.gnt == 2'b11) bad++;
            if ((bus.done & ~bus.gnt) != 2'b00) bad++;
            if (prev_gnt == 2'b00 && bus.gnt != 2'b00) begin
                grants[ng] = bus.gnt;
                ng++;
            end
            prev_gnt = bus.gnt;
        end
        chk("r27_num_grants", ng, 4);
        chk("r27_exclusive",  bad, 0);
`ifdef CNT_CTRL_FIXED_PRIO_EN
        chk("r27_g0", grants[0], 2'b01);
        chk("r27_g1", grants[1], 2'b01);
        chk("r27_g2", grants[2], 2'b01);
        chk("r27_g3", grants[3], 2'b01);
`else
        chk("r27_g0", grants[0], 2'b01);
        chk("r27_g1", grants[1], 2'b10);
        chk("r27_g2", grants[2], 2'b01);
        chk("r27_g3", grants[3], 2'b10);
`endif

        // Asynchronous reset mid-RUN, then requester 0 favoured
        do_reset();
        bus.req = 2'b10; bus.req_data1 = 4'd0;
        tick();
        chk("r30_gnt_pre", bus.gnt, 2'b10);
        tick(); tick(); tick();
        chk("r30_busy_pre", bus.busy, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("r30_gnt",      bus.gnt,      2'b00);
        chk("r30_done",     bus.done,     2'b00);
        chk("r30_cnt_load", bus.cnt_load, 1'b0);
        chk("r30_cnt_data", bus.cnt_data, 4'd0);
        chk("r30_busy",     bus.busy,     1'b0);
        bus.req = 2'b11; bus.req_data0 = 4'd13; bus.req_data1 = 4'd14;
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.done != 2'b00) dones++;
        end
        chk("r30_no_done", dones, 0);
        rst = 1'b1;
        tick();
        chk("r30_first_gnt", bus.gnt, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
